// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - Clause-22 MDIO master; optional macro MDIO_PREAMBLE_SUPPRESS_EN adds req_no_preamble
module mdio_master #(
  parameter int CLK_DIV = 25
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phy_addr,
  input  logic [4:0]  req_reg_addr,
  input  logic [15:0] req_wdata,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  input  logic        req_no_preamble,
`endif
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic        mdio_in
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  // Bit indices are absolute frame positions; a preamble-less frame starts at 32.
  localparam logic [5:0] BIT_ST   = 6'd32;
  localparam logic [5:0] BIT_TA1  = 6'd46;
  localparam logic [5:0] BIT_TA2  = 6'd47;
  localparam logic [5:0] BIT_DATA = 6'd48;
  localparam logic [5:0] BIT_LAST = 6'd63;

  state_t      state_q;
  logic [7:0]  div_q;
  logic [5:0]  bit_q;
  logic [63:0] sr_q;
  logic        write_q;
  logic        mdc_q;
  logic        mdio_oe_q;
  logic        resp_valid_q;
  logic [15:0] resp_rdata_q;
  logic        resp_err_q;
  logic [15:0] rx_q;
  logic        rx_err_q;
  logic        sync1_q;
  logic        sync2_q;

  logic        no_pre;
  logic        accept;
  logic [63:0] frame_full;
  logic [63:0] frame_d;
  logic [5:0]  bit_d;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign no_pre = req_no_preamble;
`else
  assign no_pre = 1'b0;
`endif

  assign req_ready  = (state_q == IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign bit_d      = bit_q + 6'd1;

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mdc        = mdc_q;
  assign mdio_out   = sr_q[63];
  assign mdio_oe    = mdio_oe_q;

  // Frame image; released read bits (TA and DATA) are loaded as ones so mdio_out idles high.
  always_comb begin
    frame_full = {32'hFFFF_FFFF, 2'b01, (req_write ? 2'b01 : 2'b10),
                  req_phy_addr, req_reg_addr,
                  (req_write ? {2'b10, req_wdata} : 18'h3FFFF)};
    frame_d    = no_pre ? {frame_full[31:0], 32'hFFFF_FFFF} : frame_full;
  end

  // Two-flop synchronizer for the asynchronous pad readback.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= mdio_in;
      sync2_q <= sync1_q;
    end
  end

  // Frame sequencer: divider, bit counter, shift register, sampling and completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      div_q        <= 8'd0;
      bit_q        <= 6'd0;
      sr_q         <= 64'd0;
      write_q      <= 1'b0;
      mdc_q        <= 1'b0;
      mdio_oe_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 16'd0;
      resp_err_q   <= 1'b0;
      rx_q         <= 16'd0;
      rx_err_q     <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          div_q <= 8'd0;
          bit_q <= 6'd0;
          if (accept) begin
            state_q   <= SHIFT;
            sr_q      <= frame_d;
            write_q   <= req_write;
            bit_q     <= no_pre ? BIT_ST : 6'd0;
            mdc_q     <= 1'b0;
            mdio_oe_q <= 1'b1;
          end
        end
        SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_q <= 8'd0;
            if (!mdc_q) begin
              // Rising MDC: sample the synchronized pad for read frames.
              mdc_q <= 1'b1;
              if (!write_q && bit_q == BIT_TA2) rx_err_q <= sync2_q;
              if (!write_q && bit_q >= BIT_DATA) rx_q <= {rx_q[14:0], sync2_q};
            end else if (bit_q == BIT_LAST) begin
              state_q      <= IDLE;
              bit_q        <= 6'd0;
              mdc_q        <= 1'b0;
              mdio_oe_q    <= 1'b0;
              sr_q         <= 64'd0;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= write_q ? 16'd0 : rx_q;
              resp_err_q   <= write_q ? 1'b0 : rx_err_q;
            end else begin
              // Falling MDC: start of the next bit.
              mdc_q     <= 1'b0;
              bit_q     <= bit_d;
              sr_q      <= {sr_q[62:0], 1'b0};
              mdio_oe_q <= write_q || (bit_d < BIT_TA1);
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// tb/tb_mdio_master.sv - scoreboard bench for mdio_master with CLK_DIV=4
module tb_mdio_master;

  localparam int CLK_DIV  = 4;
  localparam int BIT_CLKS = 2 * CLK_DIV;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [4:0]  req_phy_addr = 5'd0;
  logic [4:0]  req_reg_addr = 5'd0;
  logic [15:0] req_wdata = 16'd0;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  logic        req_no_preamble = 1'b0;
`endif
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        mdc;
  logic        mdio_out;
  logic        mdio_oe;
  logic        mdio_in;

  always #5 clock = ~clock;

  mdio_master #(.CLK_DIV(CLK_DIV)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_phy_addr (req_phy_addr),
    .req_reg_addr (req_reg_addr),
    .req_wdata    (req_wdata),
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    .req_no_preamble (req_no_preamble),
`endif
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mdc          (mdc),
    .mdio_out     (mdio_out),
    .mdio_oe      (mdio_oe),
    .mdio_in      (mdio_in)
  );

  typedef struct {
    logic [63:0] exp_out;
    logic [63:0] exp_oe;
    logic [15:0] rdata;
    logic        err;
    int          cycle;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          cur_t = -100000;
  int          phy_k;
  logic        cur_read = 1'b0;
  logic        phy_present = 1'b0;
  logic [15:0] phy_data = 16'd0;
  logic [63:0] cap_out = 64'd0;
  logic [63:0] cap_oe = 64'd0;
  logic        mdc_prev = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pad model: DUT drive wins, else PHY answers a read (0 on TA bit 2, then data), else pull-up.
  always_comb begin
    phy_k = (cyc - cur_t - 1) / BIT_CLKS;
    if (mdio_oe) mdio_in = mdio_out;
    else if (phy_present && cur_read && phy_k == 47) mdio_in = 1'b0;
    else if (phy_present && cur_read && phy_k >= 48 && phy_k <= 63) mdio_in = phy_data[63 - phy_k];
    else mdio_in = 1'b1;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: collect bits at rising MDC, compare responses against the scoreboard.
  always @(negedge clock) begin
    if (reset) begin
      sb_q.delete();
      cap_out = 64'd0;
      cap_oe  = 64'd0;
    end else begin
      if (mdc && !mdc_prev) begin
        cap_out = {cap_out[62:0], mdio_out};
        cap_oe  = {cap_oe[62:0], mdio_oe};
      end
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_resp", 64'd1, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("resp_cycle", 64'(cyc), 64'(mon_e.cycle));
          check("resp_rdata", 64'(resp_rdata), 64'(mon_e.rdata));
          check("resp_err", 64'(resp_err), 64'(mon_e.err));
          check("frame_bits", cap_out, mon_e.exp_out);
          check("frame_oe", cap_oe, mon_e.exp_oe);
          check("ready_on_resp", 64'(req_ready), 64'd1);
        end
        cap_out = 64'd0;
        cap_oe  = 64'd0;
      end
    end
    mdc_prev = mdc;
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  // Presents one request, waits for acceptance, pushes the expected result.
  task automatic send(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                      input logic [15:0] wd, input logic nopre, input logic present,
                      input logic [15:0] pdata, input logic hold, output int t);
    exp_t        e;
    logic [63:0] full_out;
    logic [63:0] full_oe;
    int          n;
    int          guard;
    req_write    = wr;
    req_phy_addr = phy;
    req_reg_addr = rg;
    req_wdata    = wd;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    req_no_preamble = nopre;
`endif
    req_valid    = 1'b1;
    guard = 0;
    while (!req_ready && guard < 2000) begin
      @(negedge clock);
      guard++;
    end
    t = cyc;
    if (!req_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    if (!hold) req_valid = 1'b0;
    cur_t       = nopre ? t - 32 * BIT_CLKS : t;
    cur_read    = !wr;
    phy_present = present;
    phy_data    = pdata;
    full_out = {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), phy, rg,
                (wr ? {2'b10, wd} : 18'h3FFFF)};
    full_oe  = wr ? {64{1'b1}} : {{46{1'b1}}, 18'd0};
    n = nopre ? 32 : 64;
    e.exp_out = nopre ? {32'd0, full_out[31:0]} : full_out;
    e.exp_oe  = nopre ? {32'd0, full_oe[31:0]} : full_oe;
    e.rdata   = wr ? 16'd0 : (present ? pdata : 16'hFFFF);
    e.err     = !wr && !present;
    e.cycle   = t + 1 + n * BIT_CLKS;
    sb_q.push_back(e);
    @(negedge clock);
    check("first_bit_mdc", 64'(mdc), 64'd0);
    check("first_bit_oe", 64'(mdio_oe), 64'd1);
    check("first_bit_out", 64'(mdio_out), 64'(!nopre));
  endtask

  initial begin
    int t;
    int t1;
    int t2;
    int guard;

    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_mdc", 64'(mdc), 64'd0);
    check("rst_mdio_out", 64'(mdio_out), 64'd0);
    check("rst_mdio_oe", 64'(mdio_oe), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", 64'(req_ready), 64'd1);

    send(1'b1, 5'h01, 5'h00, 16'h1140, 1'b0, 1'b0, 16'h0, 1'b0, t);

    send(1'b0, 5'h01, 5'h02, 16'h0, 1'b0, 1'b1, 16'h0141, 1'b0, t);
    wait_cyc(t + 46 * BIT_CLKS);
    check("oe_before_ta", 64'(mdio_oe), 64'd1);
    @(negedge clock);
    check("oe_at_ta", 64'(mdio_oe), 64'd0);
    check("out_released", 64'(mdio_out), 64'd1);

    send(1'b0, 5'h03, 5'h01, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, t);

    send(1'b1, 5'h1F, 5'h1F, 16'hA5C3, 1'b0, 1'b0, 16'h0, 1'b1, t1);
    send(1'b0, 5'h0A, 5'h11, 16'h0, 1'b0, 1'b1, 16'h8001, 1'b0, t2);
    check("b2b_accept", 64'(t2), 64'(t1 + 1 + 64 * BIT_CLKS));

    send(1'b1, 5'h02, 5'h04, 16'hBEEF, 1'b0, 1'b0, 16'h0, 1'b0, t);
    wait_cyc(t + 200);
    reset = 1'b1;
    @(negedge clock);
    check("abort_mdc", 64'(mdc), 64'd0);
    check("abort_oe", 64'(mdio_oe), 64'd0);
    check("abort_ready", 64'(req_ready), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("abort_ready_after", 64'(req_ready), 64'd1);
    repeat (600) @(negedge clock);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    send(1'b1, 5'h01, 5'h00, 16'h1140, 1'b1, 1'b0, 16'h0, 1'b0, t);
    send(1'b0, 5'h01, 5'h02, 16'h0, 1'b1, 1'b1, 16'h0141, 1'b0, t);
`endif

    send(1'b1, 5'h15, 5'h0A, 16'h0001, 1'b0, 1'b0, 16'h0, 1'b0, t);

    guard = 0;
    while (sb_q.size() != 0 && guard < 2000) begin
      @(negedge clock);
      guard++;
    end
    check("drain", 64'(sb_q.size()), 64'd0);
    repeat (4) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
